z_bitpack: RTL
==============

Name: z_bitpack

Overview:
- Downstream consumer of the mask/response vector stored in NTT data RAM, using the packed format of 4 × 24-bit coefficients per 96-bit word, values mod q.
- Reads L polynomials and encodes each coefficient as BitPack(z, gamma1-1, gamma1), i.e. stored field = (gamma1 - z) mod q, 20 bits wide.
- Streams the 20-bit fields LSB-first into 64-bit words and writes them to the raw data RAM at the signature z-field offset.
- Flags any coefficient whose encoded value does not fit in 20 bits.

Parameters:
- L, 7, number of polynomials.
- N, 256, coefficients per polynomial.
- GAMMA1, 19, log2 of gamma1.
- Q, 8380417, modulus.
- COEFF_WIDTH, 24, bits per stored coefficient.
- COEFF_PER_WORD, 4, coefficients per NTT RAM word.
- NTT_ADDR_WIDTH, 12, NTT RAM address width.
- VECTOR_Z_BASE_OFFSET, 0, NTT RAM word address of polynomial 0, coefficients 0..3.
- WORD_WIDTH, 64, raw data RAM word width.
- DATA_ADDR_WIDTH, 12, raw data RAM address width.
- SIG_Z_OFFSET, 0, raw data RAM word address of the first packed word.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin packing; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse when the last word has been written
- range_err  out  1  sticky; cleared on start
- re_vector_z  out  1  NTT RAM read enable
- addr_vector_z  out  NTT_ADDR_WIDTH  NTT RAM read address
- dout_vector_z  in  COEFF_WIDTH*COEFF_PER_WORD  read data; valid 1 cycle after re; coefficient k in bits [24k+:24]
- we_sig  out  1  raw RAM write enable
- addr_sig  out  DATA_ADDR_WIDTH  raw RAM write address
- din_sig  out  WORD_WIDTH  raw RAM write data

Behaviour:
- Reset values: busy=0, done=0, range_err=0, re_vector_z=0, addr_vector_z=0, we_sig=0, addr_sig=0, din_sig=0. Internally, state=IDLE and all counters and the 84-bit pack buffer are 0.
- States and transitions:
  - IDLE: on start, clear counters, buffer and range_err, then go to READ.
  - READ: 1 cycle. re_vector_z=1, addr_vector_z = VECTOR_Z_BASE_OFFSET + rd_cnt. Go to WAIT.
  - WAIT: 1 cycle. re=0. At the end of this cycle, latch dout_vector_z into the word register. Go to PACK.
  - PACK: exactly 4 cycles; coefficient index k = 0..3, one coefficient per cycle.
    - After k=3: rd_cnt += 1. If rd_cnt reaches L*N/4 (448), go to FIN; otherwise go to READ.
  - FIN: 1 cycle. done=1, busy=0 at the next edge. Go to IDLE.
- Timing: 6 cycles per NTT word. Total from start to done is 2688 + 2 cycles.
- Encoding: c = coefficient k (24 bits, assumed < Q).
  - If c <= gamma1: v = gamma1 - c.
  - Else: v = gamma1 - c + Q.
  - All arithmetic is 25-bit unsigned.
  - If v >= 2^20: set range_err=1 (sticky) and pack v[19:0] anyway.
- Packing, per PACK cycle:
  - tmp = buf | (v[19:0] << bit_cnt); nb = bit_cnt + 20.
  - If nb >= 64: we_sig=1, din_sig = tmp[63:0], addr_sig = SIG_Z_OFFSET + wr_cnt, wr_cnt += 1, buf = tmp >> 64, bit_cnt = nb - 64.
  - Otherwise: buf = tmp, bit_cnt = nb, we_sig=0.
- Write asserts on the edge after the PACK cycle in which the word completes; we_sig is a single-cycle pulse.
- 5120 bits per polynomial is 80 whole words, so bit_cnt is 0 at every polynomial boundary. No flush is needed.
- Total writes are 560, at addresses SIG_Z_OFFSET .. SIG_Z_OFFSET+559.
- start asserted while busy is ignored.
- rst mid-operation: immediate return to IDLE with all outputs at their reset values. No further writes occur, and partial words are discarded.
- dout_vector_z is sampled only at the end of WAIT.

Test Plan:
- All coefficients 0: v=0x80000 for every field. Word 0 = 0x0800_0080_0008_0000. 560 writes in total, done after 2690 cycles, range_err=0.
- All coefficients = gamma1 (524288): v=0. Every write is 0x0000_0000_0000_0000.
- All coefficients = Q - gamma1 + 1 (7856130): v=0xFFFFF. Every write is 0xFFFF_FFFF_FFFF_FFFF, range_err=0.
- Ramp z = index mod Q across the full vector: compare all 560 words against the FIPS 204 BitPack software model. Check the last address is SIG_Z_OFFSET+559.
- Single coefficient z = gamma1+1 in polynomial 3: v = Q-1, so range_err rises during that PACK cycle and stays high. Packed field = (Q-1)[19:0] = 0xFE000. All other words are unaffected.
- Two cases:
  - Assert rst during polynomial 2: no further we_sig, outputs return to reset values.
  - Then issue a new start: a full correct run, and a start pulse sent while busy has no effect.

Source files
------------

// File: rtl/z_bitpack_if.sv
// Handshake and memory-port bundle for z_bitpack. The slave side is the packer.
// The master side is its controller together with the NTT/raw RAM models.
interface z_bitpack_if #(
    parameter int NTT_ADDR_WIDTH  = 12,
    parameter int COEFF_WIDTH     = 24,
    parameter int COEFF_PER_WORD  = 4,
    parameter int DATA_ADDR_WIDTH = 12,
    parameter int WORD_WIDTH      = 64
);
    logic                                  start;
    logic                                  busy;
    logic                                  done;
    logic                                  range_err;
    logic                                  re_vector_z;
    logic [NTT_ADDR_WIDTH-1:0]             addr_vector_z;
    logic [COEFF_WIDTH*COEFF_PER_WORD-1:0] dout_vector_z;
    logic                                  we_sig;
    logic [DATA_ADDR_WIDTH-1:0]            addr_sig;
    logic [WORD_WIDTH-1:0]                 din_sig;

    modport master (
        output start, dout_vector_z,
        input  busy, done, range_err, re_vector_z, addr_vector_z,
        input  we_sig, addr_sig, din_sig
    );

    modport slave (
        input  start, dout_vector_z,
        output busy, done, range_err, re_vector_z, addr_vector_z,
        output we_sig, addr_sig, din_sig
    );
endinterface

// File: rtl/z_bitpack.sv
// Packs the signature z vector. Each coefficient is encoded as (gamma1 - z) mod q in a 20-bit field.
// The fields are streamed LSB-first into 64-bit raw RAM words.
module z_bitpack #(
    parameter int L                    = 7,
    parameter int N                    = 256,
    parameter int GAMMA1               = 19,
    parameter int Q                    = 8380417,
    parameter int COEFF_WIDTH          = 24,
    parameter int COEFF_PER_WORD       = 4,
    parameter int NTT_ADDR_WIDTH       = 12,
    parameter int VECTOR_Z_BASE_OFFSET = 0,
    parameter int WORD_WIDTH           = 64,
    parameter int DATA_ADDR_WIDTH      = 12,
    parameter int SIG_Z_OFFSET         = 0
) (
    input  logic       clk,
    input  logic       rst,
    z_bitpack_if.slave bus
);
    localparam int FIELD_W = GAMMA1 + 1;
    localparam int BUF_W   = WORD_WIDTH + FIELD_W;
    localparam int CNT_W   = $clog2(BUF_W);

    localparam logic [24:0]                GAMMA1_V  = 25'(1) << GAMMA1;
    localparam logic [24:0]                Q_V       = 25'(Q);
    localparam logic [24:0]                FIELD_LIM = 25'(1) << FIELD_W;
    localparam logic [CNT_W-1:0]           FIELD_C   = CNT_W'(FIELD_W);
    localparam logic [CNT_W-1:0]           WORD_C    = CNT_W'(WORD_WIDTH);
    localparam logic [NTT_ADDR_WIDTH-1:0]  RD_BASE   = NTT_ADDR_WIDTH'(VECTOR_Z_BASE_OFFSET);
    localparam logic [NTT_ADDR_WIDTH-1:0]  RD_LAST   = NTT_ADDR_WIDTH'(L * N / COEFF_PER_WORD - 1);
    localparam logic [DATA_ADDR_WIDTH-1:0] WR_BASE   = DATA_ADDR_WIDTH'(SIG_Z_OFFSET);

    typedef enum logic [2:0] {IDLE, READ, WAIT, PACK, FIN} state_t;

    state_t                                state;
    logic [NTT_ADDR_WIDTH-1:0]             rd_cnt;
    logic [DATA_ADDR_WIDTH-1:0]            wr_cnt;
    logic [CNT_W-1:0]                      bit_cnt;
    logic [1:0]                            k;
    logic [COEFF_WIDTH*COEFF_PER_WORD-1:0] word_q;
    logic [BUF_W-1:0]                      pack_buf;

    logic [COEFF_WIDTH-1:0] coeff;
    logic [24:0]            v;
    logic [BUF_W-1:0]       tmp;
    logic [CNT_W-1:0]       nb;

    // Encode the current coefficient and merge it into the pending bit buffer.
    always_comb begin
        coeff = word_q[32'(k) * COEFF_WIDTH +: COEFF_WIDTH];
        if ({1'b0, coeff} <= GAMMA1_V)
            v = GAMMA1_V - {1'b0, coeff};
        else
            v = GAMMA1_V - {1'b0, coeff} + Q_V;
        tmp = pack_buf | (BUF_W'(v[FIELD_W-1:0]) << bit_cnt);
        nb  = bit_cnt + FIELD_C;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            rd_cnt            <= '0;
            wr_cnt            <= '0;
            bit_cnt           <= '0;
            k                 <= '0;
            word_q            <= '0;
            pack_buf          <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.range_err     <= 1'b0;
            bus.re_vector_z   <= 1'b0;
            bus.addr_vector_z <= '0;
            bus.we_sig        <= 1'b0;
            bus.addr_sig      <= '0;
            bus.din_sig       <= '0;
        end else begin
            bus.we_sig      <= 1'b0;
            bus.re_vector_z <= 1'b0;
            bus.done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rd_cnt            <= '0;
                        wr_cnt            <= '0;
                        bit_cnt           <= '0;
                        k                 <= '0;
                        pack_buf          <= '0;
                        bus.range_err     <= 1'b0;
                        bus.busy          <= 1'b1;
                        bus.re_vector_z   <= 1'b1;
                        bus.addr_vector_z <= RD_BASE;
                        state             <= READ;
                    end
                end
                READ: state <= WAIT;
                WAIT: begin
                    word_q <= bus.dout_vector_z;
                    state  <= PACK;
                end
                PACK: begin
                    if (v >= FIELD_LIM)
                        bus.range_err <= 1'b1;
                    if (nb >= WORD_C) begin
                        bus.we_sig   <= 1'b1;
                        bus.din_sig  <= tmp[WORD_WIDTH-1:0];
                        bus.addr_sig <= WR_BASE + wr_cnt;
                        wr_cnt       <= wr_cnt + 1'b1;
                        pack_buf     <= tmp >> WORD_WIDTH;
                        bit_cnt      <= nb - WORD_C;
                    end else begin
                        pack_buf <= tmp;
                        bit_cnt  <= nb;
                    end
                    k <= k + 1'b1;
                    // The read for the next NTT word is issued as soon as the last coefficient is consumed.
                    if (k == 2'd3) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == RD_LAST) begin
                            bus.done <= 1'b1;
                            state    <= FIN;
                        end else begin
                            bus.re_vector_z   <= 1'b1;
                            bus.addr_vector_z <= RD_BASE + rd_cnt + 1'b1;
                            state             <= READ;
                        end
                    end
                end
                FIN: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
